// File: rtl/mp64_extmem_ctrl.sv
// External-memory PHY initiator: one command (single or burst, read or write) in flight at a time.
// Write beats follow a fixed WR_LAT schedule; read beats are re-registered (latency 1) under a per-beat timeout.
module mp64_extmem_ctrl #(
    parameter int WR_LAT     = 2,
    parameter int RD_TIMEOUT = 1024,
    parameter int TO_W       = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wen,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_beats_m1,
    input  logic        wbuf_we,
    input  logic [3:0]  wbuf_idx,
    input  logic [63:0] wbuf_data,
    output logic        rd_valid,
    output logic [3:0]  rd_idx,
    output logic [63:0] rd_data,
    output logic        done,
    output logic        err_timeout,
    output logic        err_stray,
    output logic        phy_req,
    output logic [31:0] phy_addr,
    output logic        phy_wen,
    output logic [63:0] phy_wdata,
    output logic [3:0]  phy_burst_len,
    input  logic [63:0] phy_rdata,
    input  logic        phy_rvalid,
    input  logic        phy_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WDATA,
        S_RDATA,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] WR_WAIT = TO_W'(WR_LAT - 1);
    localparam logic [TO_W-1:0] RD_LIM  = TO_W'(RD_TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

    state_t            state_q, state_d;
    logic              wen_q, wen_d;
    logic [28:0]       addr_q, addr_d;
    logic [3:0]        beats_q, beats_d;
    logic [3:0]        beat_q, beat_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              to_flag_q, to_flag_d;
    logic              stray_q, stray_d;
    logic              rd_valid_q, rd_valid_d;
    logic [3:0]        rd_idx_q, rd_idx_d;
    logic [63:0]       rd_data_q, rd_data_d;

    logic [63:0]       wbuf_q [16];

    // Byte-offset bits of the command address are architecturally ignored.
    logic              addr_lsb_unused;
    assign addr_lsb_unused = ^cmd_addr[2:0];

    // Write buffer is plain storage: no reset, writable in any state.
    always_ff @(posedge sys_clk) begin
        if (wbuf_we) begin
            wbuf_q[wbuf_idx] <= wbuf_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            to_flag_q  <= 1'b0;
            stray_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            to_flag_q  <= to_flag_d;
            stray_q    <= stray_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        to_flag_d  = to_flag_q;
        stray_d    = stray_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;

        // Any read beat the FSM is not collecting is discarded and flagged.
        if (phy_rvalid && (state_q != S_RDATA)) begin
            stray_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wen_d     = cmd_wen;
                    addr_d    = cmd_addr[31:3];
                    beats_d   = cmd_beats_m1;
                    beat_d    = '0;
                    cnt_d     = '0;
                    to_flag_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (phy_ready) begin
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = wen_q ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                // cnt_q counts edges since the request until the PHY starts consuming beats.
                if (cnt_q < WR_WAIT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (beat_q == beats_q) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            S_RDATA: begin
                if (phy_rvalid) begin
                    rd_valid_d = 1'b1;
                    rd_idx_d   = beat_q;
                    rd_data_d  = phy_rdata;
                    cnt_d      = '0;
                    if (beat_q == beats_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else if (cnt_q == RD_LIM) begin
                    cnt_d     = cnt_q + CNT_ONE;
                    to_flag_d = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (phy_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request and completion strobes decode straight from the state register so reset kills them at once.
    assign cmd_ready     = (state_q == S_IDLE);
    assign phy_req       = (state_q == S_ISSUE) && phy_ready;
    assign phy_wen       = wen_q && ((state_q == S_ISSUE) || (state_q == S_WDATA));
    assign phy_addr      = {addr_q, 3'b000};
    assign phy_burst_len = beats_q;
    assign phy_wdata     = (state_q == S_WDATA) ? wbuf_q[beat_q] : 64'd0;
    assign done          = (state_q == S_DONE);
    assign err_timeout   = (state_q == S_DONE) && to_flag_q;
    assign err_stray     = stray_q;
    assign rd_valid      = rd_valid_q;
    assign rd_idx        = rd_idx_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_mp64_extmem_ctrl.sv
// Bench for mp64_extmem_ctrl: behavioural PHY + memory, transaction-level scoreboard and directed scenarios.
module tb_mp64_extmem_ctrl;

    localparam int WR_LAT     = 2;
    localparam int RD_TIMEOUT = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_wen = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_beats_m1 = '0;
    logic        wbuf_we = 1'b0;
    logic [3:0]  wbuf_idx = '0;
    logic [63:0] wbuf_data = '0;
    logic        cmd_ready, rd_valid, done, err_timeout, err_stray, phy_req, phy_wen;
    logic [3:0]  rd_idx, phy_burst_len;
    logic [63:0] rd_data, phy_wdata;
    logic [31:0] phy_addr;
    logic [63:0] phy_rdata;
    logic        phy_rvalid, phy_ready;

    mp64_extmem_ctrl #(.WR_LAT(WR_LAT), .RD_TIMEOUT(RD_TIMEOUT), .TO_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
        .cmd_addr(cmd_addr), .cmd_beats_m1(cmd_beats_m1),
        .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx), .wbuf_data(wbuf_data),
        .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
        .done(done), .err_timeout(err_timeout), .err_stray(err_stray),
        .phy_req(phy_req), .phy_addr(phy_addr), .phy_wen(phy_wen),
        .phy_wdata(phy_wdata), .phy_burst_len(phy_burst_len),
        .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid), .phy_ready(phy_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory behind the PHY and the bench's own idea of what it should hold.
    logic [63:0] ext_mem   [2048];
    logic [63:0] model_mem [2048];
    logic [63:0] wbuf_model [16];

    typedef struct {
        int         due;
        logic [3:0] idx;
        logic [63:0] dat;
    } rdexp_t;
    rdexp_t exp_rd [$];

    // Scoreboard state for the command in flight.
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    logic        exp_wen, exp_to;
    int          exp_pending = 0;
    int          req_cnt = 0, done_cnt = 0, n_rd = 0;
    int          e0_cyc = -1, done_cyc = -1, last_rv_cyc = -1, stray_due = -1;
    logic [31:0] req_addr_log;
    logic [3:0]  req_len_log;
    logic        to_at_done;
    logic [63:0] rd_log [16];
    int          rd_cyc [16];
    int          wr_edge [16];
    bit          run_chk = 0;

    // PHY control knobs.
    bit hold_ready_low = 0, no_rvalid = 0, inject_stray = 0;

    // Behavioural PHY: accepts a request at E0, consumes write beat k at edge E0+WR_LAT+k,
    // returns read beat k in the cycle after edge E0+k, and is busy (ready low) meanwhile.
    initial begin
        bit          acc;
        logic [31:0] a_addr;
        logic [3:0]  a_len;
        logic        a_wr;
        bit          p_busy = 0, p_wr = 0;
        int          p_t = 0, p_len = 0, p_base = 0;
        phy_ready  = 1'b1;
        phy_rvalid = 1'b0;
        phy_rdata  = '0;
        forever begin
            @(negedge sys_clk);
            acc = sys_rst_n && phy_req && phy_ready;
            if (p_busy && p_wr && (p_t + 1 >= WR_LAT) && (p_t + 1 - WR_LAT <= p_len)) begin
                ext_mem[p_base + p_t + 1 - WR_LAT] = phy_wdata;
                wr_edge[p_t + 1 - WR_LAT] = cyc + 1;
            end
            if (acc) begin
                a_addr = phy_addr;
                a_len  = phy_burst_len;
                a_wr   = phy_wen;
            end
            @(posedge sys_clk);
            #1;
            phy_rvalid = 1'b0;
            if (acc) begin
                p_busy = 1; p_t = 0; p_base = int'(a_addr >> 3); p_len = int'(a_len); p_wr = a_wr;
                phy_ready = 1'b0;
            end else if (p_busy) begin
                p_t++;
            end
            if (p_busy && !p_wr && !no_rvalid && p_t <= p_len) begin
                phy_rvalid = 1'b1;
                phy_rdata  = ext_mem[p_base + p_t];
                exp_rd.push_back('{cyc + 1, 4'(p_t), model_mem[p_base + p_t]});
                last_rv_cyc = cyc;
            end
            if (p_busy && ((p_wr && p_t == WR_LAT + p_len) ||
                           (!p_wr && !no_rvalid && p_t == p_len + 1) ||
                           (!p_wr && no_rvalid && p_t == 5))) begin
                p_busy = 0;
            end
            if (inject_stray) begin
                phy_rvalid   = 1'b1;
                phy_rdata    = 64'h5757_5757_5757_5757;
                stray_due    = cyc + 1;
                inject_stray = 0;
            end
            phy_ready = (!hold_ready_low && !p_busy) ? 1'b1 : 1'b0;
        end
    end

    // Scoreboard: every cycle out of reset.
    always @(negedge sys_clk) begin
        if (sys_rst_n && run_chk) begin
            if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
                chk("rd_valid", rd_valid, 1'b1);
                chk("rd_idx", rd_idx, exp_rd[0].idx);
                chk("rd_data", rd_data, exp_rd[0].dat);
                rd_log[exp_rd[0].idx] = rd_data;
                rd_cyc[exp_rd[0].idx] = cyc;
                n_rd++;
                void'(exp_rd.pop_front());
            end else begin
                chk("rd_valid_idle", rd_valid, 1'b0);
            end
            if (phy_req) begin
                chk("req_addr", phy_addr, exp_addr);
                chk("req_len", phy_burst_len, exp_len);
                chk("req_wen", phy_wen, exp_wen);
                chk("req_once", req_cnt, 0);
                req_cnt++;
                req_addr_log = phy_addr;
                req_len_log  = phy_burst_len;
                e0_cyc = cyc + 1;
            end
            if (done) begin
                chk("done_expected", exp_pending, 1);
                chk("err_timeout", err_timeout, exp_to);
                exp_pending = 0;
                done_cnt++;
                done_cyc   = cyc;
                to_at_done = err_timeout;
            end else begin
                chk("err_timeout_idle", err_timeout, 1'b0);
            end
            chk("err_stray", err_stray, (stray_due >= 0 && cyc >= stray_due));
        end
    end

    task automatic load_wbuf(input int n, input logic [63:0] base, input logic [63:0] step);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk); #2;
            wbuf_we = 1'b1; wbuf_idx = 4'(k); wbuf_data = base + step * 64'(k);
            wbuf_model[k] = base + step * 64'(k);
        end
        @(posedge sys_clk); #2;
        wbuf_we = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] bm1, input logic to);
        bit acc = 0;
        exp_addr = {a[31:3], 3'b000}; exp_len = bm1; exp_wen = w; exp_to = to;
        req_cnt = 0; done_cnt = 0; exp_pending = 1;
        if (w) begin
            for (int k = 0; k <= int'(bm1); k++) model_mem[int'(a >> 3) + k] = wbuf_model[k];
        end
        @(posedge sys_clk); #2;
        cmd_valid = 1'b1; cmd_wen = w; cmd_addr = a; cmd_beats_m1 = bm1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge sys_clk);
            if (cmd_ready) acc = 1;
        end
        @(posedge sys_clk); #2;
        cmd_valid = 1'b0;
        chk("cmd_accepted", acc, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge sys_clk);
            if (done) got = 1;
        end
        chk(tag, got, 1'b1);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ext_mem[i]   = 64'h0BAD_0000_0000_0000 + 64'(i) * 64'h1_0001;
            model_mem[i] = ext_mem[i];
        end
        ext_mem[32'h21]   = 64'hDEADBEEF_CAFEF00D;
        model_mem[32'h21] = 64'hDEADBEEF_CAFEF00D;

        // Reset state.
        #3 sys_rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_phy_req", phy_req, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_err_stray", err_stray, 1'b0);
        chk("rst_phy_addr", phy_addr, 32'h0);
        chk("rst_phy_wdata", phy_wdata, 64'h0);
        chk("rst_phy_len", phy_burst_len, 4'h0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        run_chk = 1;

        // Single read at 0x108.
        issue(1'b0, 32'h0000_0108, 4'd0, 1'b0);
        wait_done("t1_done", 100);
        chk("t1_addr", req_addr_log, 32'h0000_0108);
        chk("t1_len", req_len_log, 4'd0);
        chk("t1_nbeats", n_rd, 1);
        chk("t1_data", rd_log[0], 64'hDEADBEEF_CAFEF00D);
        chk("t1_done_lat", done_cyc - last_rv_cyc, 2);

        // Burst write of four beats to 0x1000.
        load_wbuf(4, 64'h11, 64'h11);
        issue(1'b1, 32'h0000_1000, 4'd3, 1'b0);
        wait_done("t2_done", 100);
        for (int k = 0; k < 4; k++) begin
            chk("t2_mem_model", ext_mem[32'h200 + k], model_mem[32'h200 + k]);
            chk("t2_wr_edge", wr_edge[k] - e0_cyc, WR_LAT + k);
        end
        chk("t2_mem0", ext_mem[32'h200], 64'h11);
        chk("t2_mem3", ext_mem[32'h203], 64'h44);

        // Full 16-beat read of the same region straight afterwards.
        n_rd = 0;
        issue(1'b0, 32'h0000_1000, 4'd15, 1'b0);
        wait_done("t3_done", 200);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("t3_nbeats", n_rd, 16);
        chk("t3_rd0", rd_log[0], 64'h11);
        chk("t3_rd1", rd_log[1], 64'h22);
        chk("t3_rd2", rd_log[2], 64'h33);
        chk("t3_rd3", rd_log[3], 64'h44);
        chk("t3_back_to_back", rd_cyc[15] - rd_cyc[0], 15);
        chk("t3_one_done", done_cnt, 1);

        // PHY busy for 50 cycles with a command waiting; address low bits must be dropped.
        hold_ready_low = 1;
        repeat (2) @(posedge sys_clk);
        issue(1'b0, 32'h0000_0337, 4'd0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            chk("t4_no_req", phy_req, 1'b0);
        end
        @(posedge sys_clk); #2;
        hold_ready_low = 0;
        begin
            bit seen = 0;
            int rise_cyc = -1;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge sys_clk);
                if (phy_ready) begin seen = 1; rise_cyc = cyc; end
            end
            chk("t4_ready_rose", seen, 1'b1);
            wait_done("t4_done", 100);
            chk("t4_e0", e0_cyc, rise_cyc + 1);
            chk("t4_addr", req_addr_log, 32'h0000_0330);
        end

        // PHY that never returns data: timeout counted from E0.
        no_rvalid = 1;
        n_rd = 0;
        issue(1'b0, 32'h0000_3000, 4'd2, 1'b1);
        wait_done("t5_done", 200);
        // Counter reaches RD_TIMEOUT at edge E0+RD_TIMEOUT; the drain step adds one edge.
        chk("t5_done_time", done_cyc, e0_cyc + RD_TIMEOUT + 1);
        chk("t5_timeout_flag", to_at_done, 1'b1);
        chk("t5_no_beats", n_rd, 0);
        @(negedge sys_clk);
        chk("t5_cmd_ready", cmd_ready, 1'b1);
        no_rvalid = 0;

        // Stray beat while idle, then reset in the middle of a write burst.
        @(posedge sys_clk); #2;
        inject_stray = 1;
        repeat (3) @(negedge sys_clk);
        chk("t6_stray_set", err_stray, 1'b1);
        repeat (10) @(negedge sys_clk);
        chk("t6_stray_held", err_stray, 1'b1);
        load_wbuf(8, 64'hA000, 64'h1);
        issue(1'b1, 32'h0000_2000, 4'd7, 1'b0);
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge sys_clk);
                if (req_cnt == 1) seen = 1;
            end
            chk("t6_req_seen", seen, 1'b1);
        end
        repeat (3) @(negedge sys_clk);
        #2;
        sys_rst_n   = 1'b0;
        exp_pending = 0;
        stray_due   = -1;
        exp_rd.delete();
        #1;
        chk("t6_rst_phy_req", phy_req, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
        chk("t6_rst_err_stray", err_stray, 1'b0);
        chk("t6_rst_phy_wdata", phy_wdata, 64'h0);
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("t6_post_cmd_ready", cmd_ready, 1'b1);
        chk("t6_post_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
